// File: rtl/ov5640_dvp_gen.sv
// OV5640-style DVP transmitter: emits vsync/href/8-bit RGB565 bytes (high byte first)
// sourced from an external ready/valid pixel stream or an internal test pattern.
module ov5640_dvp_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_BLANK     = 160,
  parameter int   VSYNC_LINES = 4,
  parameter int   V_BACK      = 16,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 8,
  parameter logic VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        underflow,
  output logic [15:0] frame_cnt,
  output logic        busy
);
  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HC_W     = $clog2(LINE_LEN);
  localparam logic [HC_W-1:0] HC_LAST   = HC_W'(LINE_LEN - 1);
  localparam logic [HC_W-1:0] HREF_END  = HC_W'(2 * H_ACTIVE);
  localparam logic [HC_W-1:0] HREF_LAST = HC_W'(2 * H_ACTIVE - 1);
  localparam logic [HC_W-2:0] BAR_PIX   = (HC_W - 1)'(H_ACTIVE / 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  state_t          state_r, state_s;
  logic [HC_W-1:0] hc_r, hc_s;
  logic [15:0]     vc_r, vc_s, last_line_s;
  logic [1:0]      mode_r, mode_s;
  logic [15:0]     pix_r, pix_s, cnt_r, cnt_s, new_pix_s;
  logic            frame_end_s, href_s, fetch_s, ready_s, vsync_s, underflow_s;
  logic [7:0]      data_s;
  logic [2:0]      bar_s;

  // State register with column/line counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      hc_r    <= '0;
      vc_r    <= 16'd0;
    end else begin
      state_r <= state_s;
      hc_r    <= hc_s;
      vc_r    <= vc_s;
    end
  end

  // Next state: step through whole line periods of each frame phase
  always_comb begin
    state_s     = state_r;
    hc_s        = hc_r;
    vc_s        = vc_r;
    frame_end_s = 1'b0;
    last_line_s = 16'd0;
    case (state_r)
      VSYNC:   last_line_s = 16'(VSYNC_LINES - 1);
      VBACK:   last_line_s = 16'(V_BACK - 1);
      ACTIVE:  last_line_s = 16'(V_ACTIVE - 1);
      VFRONT:  last_line_s = 16'(V_FRONT - 1);
      default: last_line_s = 16'd0;
    endcase
    if (state_r == IDLE) begin
      hc_s = '0;
      vc_s = 16'd0;
      if (en) state_s = VSYNC;
      else    state_s = IDLE;
    end else if (hc_r != HC_LAST) begin
      hc_s = hc_r + HC_W'(1);
    end else begin
      hc_s = '0;
      if (vc_r != last_line_s) begin
        vc_s = vc_r + 16'd1;
      end else begin
        vc_s = 16'd0;
        case (state_r)
          VSYNC:  state_s = VBACK;
          VBACK:  state_s = ACTIVE;
          ACTIVE: state_s = VFRONT;
          VFRONT: begin
            frame_end_s = 1'b1;
            if (en) state_s = VSYNC;
            else    state_s = IDLE;
          end
          default: state_s = IDLE;
        endcase
      end
    end
  end

  // Output decode from the upcoming cycle's position so every output can be registered
  always_comb begin
    if (state_s == VSYNC && state_r != VSYNC) mode_s = mode;
    else                                       mode_s = mode_r;
    href_s  = (state_s == ACTIVE) && (hc_s < HREF_END);
    fetch_s = href_s && !hc_s[0];
    bar_s   = 3'(hc_s[HC_W-1:1] / BAR_PIX);
    case (mode_s)
      2'd1:    new_pix_s = bar_colour(bar_s);
      2'd2:    new_pix_s = cnt_r;
      2'd3:    new_pix_s = 16'hF800;
      default: new_pix_s = pix_valid ? pix_data : 16'h0000;
    endcase
    if (state_s == VSYNC && state_r != VSYNC) cnt_s = 16'd0;
    else if (fetch_s)                          cnt_s = cnt_r + 16'd1;
    else                                       cnt_s = cnt_r;
    pix_s = fetch_s ? new_pix_s : pix_r;
    if (!href_s)      data_s = 8'h00;
    else if (fetch_s) data_s = new_pix_s[15:8];
    else              data_s = pix_r[7:0];
    underflow_s = underflow | (fetch_s && (mode_s == 2'd0) && !pix_valid);
    // Fetch slot: the cycle right before each high byte, including the last cycle of the preceding line
    ready_s = (mode_s == 2'd0) &&
              (((state_s == ACTIVE) && hc_s[0] && (hc_s < HREF_LAST)) ||
               ((hc_s == HC_LAST) &&
                (((state_s == ACTIVE) && (vc_s != 16'(V_ACTIVE - 1))) ||
                 ((state_s == VBACK) && (vc_s == 16'(V_BACK - 1))))));
    vsync_s = (state_s == VSYNC) ? VS_POL : ~VS_POL;
  end

  // Registered DVP outputs and pixel pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvp_vsync  <= ~VS_POL;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'h00;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      frame_cnt  <= 16'd0;
      busy       <= 1'b0;
      mode_r     <= 2'd0;
      pix_r      <= 16'd0;
      cnt_r      <= 16'd0;
    end else begin
      dvp_vsync  <= vsync_s;
      dvp_href   <= href_s;
      dvp_data   <= data_s;
      pix_ready  <= ready_s;
      frame_done <= frame_end_s;
      underflow  <= underflow_s;
      frame_cnt  <= frame_cnt + {15'd0, frame_end_s};
      busy       <= (state_s != IDLE);
      mode_r     <= mode_s;
      pix_r      <= pix_s;
      cnt_r      <= cnt_s;
    end
  end
endmodule

// File: tb/tb_ov5640_dvp_gen.sv
// Self-checking bench for ov5640_dvp_gen: per-cycle comparison against a frame-position model.
module tb_ov5640_dvp_gen;
  localparam int   H_ACTIVE    = 8;
  localparam int   H_BLANK     = 4;
  localparam int   VSYNC_LINES = 1;
  localparam int   V_BACK      = 1;
  localparam int   V_ACTIVE    = 2;
  localparam int   V_FRONT     = 1;
  localparam logic VS_POL      = 1'b1;
  localparam int   LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int   FRAME_LEN   = LINE_LEN * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);
  localparam int   ACT_START   = VSYNC_LINES + V_BACK;
  localparam int   NPIX        = H_ACTIVE * V_ACTIVE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_valid = 1'b0;
  logic        pix_ready, dvp_vsync, dvp_href, frame_done, underflow, busy;
  logic [7:0]  dvp_data;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          fails = 0;
  int          frames = 0;
  int          src_idx = 0;
  logic [15:0] src_q[$];
  logic [15:0] exp_px[NPIX];
  logic        uf_exp = 1'b0;
  logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  ov5640_dvp_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .VSYNC_LINES(VSYNC_LINES),
    .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .dvp_vsync(dvp_vsync),
    .dvp_href(dvp_href), .dvp_data(dvp_data), .frame_done(frame_done),
    .underflow(underflow), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: everything follows from the cycle offset t since the first vsync cycle
  function automatic logic m_vsync(input int t);
    return (t / LINE_LEN < VSYNC_LINES) ? VS_POL : ~VS_POL;
  endfunction

  function automatic logic m_href(input int t);
    int line = t / LINE_LEN;
    int col  = t % LINE_LEN;
    return (line >= ACT_START) && (line < ACT_START + V_ACTIVE) && (col < 2 * H_ACTIVE);
  endfunction

  function automatic logic [7:0] m_data(input int t, input int m);
    int p;
    logic [15:0] px;
    if (!m_href(t)) return 8'h00;
    p = (t / LINE_LEN - ACT_START) * H_ACTIVE + (t % LINE_LEN) / 2;
    case (m)
      1:       px = bars[(p % H_ACTIVE) / (H_ACTIVE / 8)];
      2:       px = 16'(p);
      3:       px = 16'hF800;
      default: px = exp_px[p];
    endcase
    return ((t % LINE_LEN) % 2 == 0) ? px[15:8] : px[7:0];
  endfunction

  function automatic logic m_ready(input int t, input int m);
    return (m == 0) && m_href(t + 1) && (((t + 1) % LINE_LEN) % 2 == 0);
  endfunction

  task automatic check_frame(input int m, input bit first, input logic [1:0] next_mode,
                             input int drop_slot, input bit stop);
    int slot = 0;
    int consumed = src_idx;
    int t_drop = -1;
    bit fetched;
    if (m == 0) begin
      for (int k = 0; k < NPIX; k++) begin
        if (k == drop_slot) exp_px[k] = 16'h0000;
        else begin exp_px[k] = src_q[consumed]; consumed++; end
      end
      if (drop_slot >= 0)
        t_drop = (ACT_START + drop_slot / H_ACTIVE) * LINE_LEN + (drop_slot % H_ACTIVE) * 2;
      pix_data  = src_q[src_idx];
      pix_valid = (drop_slot != 0);
    end else begin
      pix_valid = 1'b0;
    end
    for (int t = 0; t < FRAME_LEN; t++) begin
      @(negedge clk);
      if (t == t_drop) uf_exp = 1'b1;
      checks++;
      if (dvp_vsync !== m_vsync(t)) begin
        fails++; $display("FAIL vsync t=%0d mode=%0d got=%b exp=%b", t, m, dvp_vsync, m_vsync(t));
      end
      checks++;
      if (dvp_href !== m_href(t)) begin
        fails++; $display("FAIL href t=%0d mode=%0d got=%b exp=%b", t, m, dvp_href, m_href(t));
      end
      checks++;
      if (dvp_data !== m_data(t, m)) begin
        fails++; $display("FAIL data t=%0d mode=%0d got=%h exp=%h", t, m, dvp_data, m_data(t, m));
      end
      checks++;
      if (pix_ready !== m_ready(t, m)) begin
        fails++; $display("FAIL pix_ready t=%0d mode=%0d got=%b exp=%b", t, m, pix_ready, m_ready(t, m));
      end
      checks++;
      if (busy !== 1'b1) begin
        fails++; $display("FAIL busy t=%0d got=%b exp=1", t, busy);
      end
      checks++;
      if (frame_done !== logic'(t == 0 && !first)) begin
        fails++; $display("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, (t == 0 && !first));
      end
      checks++;
      if (underflow !== uf_exp) begin
        fails++; $display("FAIL underflow t=%0d got=%b exp=%b", t, underflow, uf_exp);
      end
      if (t == 0) begin
        checks++;
        if (frame_cnt !== 16'(frames)) begin
          fails++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, frames);
        end
      end
      fetched = pix_ready;
      if (t == FRAME_LEN / 2) begin
        mode = next_mode;
        if (stop) en = 1'b0;
      end
      @(posedge clk);
      #1;
      if (m == 0 && fetched) begin
        if (slot != drop_slot) src_idx++;
        slot++;
        pix_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 16'h0000;
        pix_valid = (slot != drop_slot);
      end
    end
    frames++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({dvp_vsync, dvp_href, dvp_data, pix_ready, frame_done, underflow, frame_cnt, busy} !==
        {~VS_POL, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got vs=%b hr=%b d=%h rdy=%b fd=%b uf=%b cnt=%0d busy=%b",
               dvp_vsync, dvp_href, dvp_data, pix_ready, frame_done, underflow, frame_cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dvp_vsync !== ~VS_POL) begin
      fails++; $display("FAIL idle_no_en got busy=%b vsync=%b exp busy=0 vsync=%b", busy, dvp_vsync, ~VS_POL);
    end
  endtask

  task automatic test_timing_counter();
    @(negedge clk);
    mode = 2'd2;
    en   = 1'b1;
    check_frame(2, 1'b1, 2'd2, -1, 1'b0);
    check_frame(2, 1'b0, 2'd2, -1, 1'b0);
    check_frame(2, 1'b0, 2'd1, -1, 1'b0);
  endtask

  task automatic test_colour_bars();
    check_frame(1, 1'b0, 2'd3, -1, 1'b0);
  endtask

  task automatic test_solid();
    check_frame(3, 1'b0, 2'd0, -1, 1'b0);
  endtask

  task automatic test_external();
    for (int i = 0; i < 20; i++) src_q.push_back(16'h1234 + 16'(i) * 16'h4444);
    check_frame(0, 1'b0, 2'd0, -1, 1'b0);
    for (int i = 0; i < 20; i++) src_q.push_back(16'($urandom));
    check_frame(0, 1'b0, 2'(1 + $urandom_range(0, 2)), $urandom_range(0, NPIX - 1), 1'b0);
  endtask

  task automatic test_stop();
    check_frame(int'(mode), 1'b0, 2'd1, -1, 1'b1);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || dvp_vsync !== ~VS_POL) begin
      fails++; $display("FAIL stop_end got fd=%b busy=%b vsync=%b exp fd=1 busy=0 vsync=%b",
                        frame_done, busy, dvp_vsync, ~VS_POL);
    end
    checks++;
    if (frame_cnt !== 16'(frames)) begin
      fails++; $display("FAIL stop_cnt got=%0d exp=%0d", frame_cnt, frames);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dvp_href !== 1'b0 || frame_done !== 1'b0 || dvp_vsync !== ~VS_POL) begin
      fails++; $display("FAIL stop_idle got busy=%b href=%b fd=%b vsync=%b", busy, dvp_href, frame_done, dvp_vsync);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd2;
    en   = 1'b1;
    repeat (ACT_START * LINE_LEN + 6) @(negedge clk);
    checks++;
    if (dvp_href !== 1'b1) begin
      fails++; $display("FAIL mid_line_href got=%b exp=1", dvp_href);
    end
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    checks++;
    if ({dvp_vsync, dvp_href, dvp_data, pix_ready, frame_done, underflow, frame_cnt, busy} !==
        {~VS_POL, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset got vs=%b hr=%b d=%h rdy=%b fd=%b uf=%b cnt=%0d busy=%b",
               dvp_vsync, dvp_href, dvp_data, pix_ready, frame_done, underflow, frame_cnt, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dvp_href !== 1'b0 || dvp_vsync !== ~VS_POL || frame_cnt !== 16'd0) begin
      fails++; $display("FAIL no_resume got busy=%b href=%b vsync=%b cnt=%0d", busy, dvp_href, dvp_vsync, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_timing_counter();
    test_colour_bars();
    test_solid();
    test_external();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
